// File: rtl/sitcpxg_rx_pkg.sv
// rtl/sitcpxg_rx_pkg.sv - shared constants, types and helpers for the SiTCPXG RX buffer
// Contents:
//   ADDR_W_MIN/ADDR_W_MAX  legal byte-address width range of the buffer RAM
//   LANES/BYTE_W           byte-lane geometry of the 64-bit write/read words
//   SIZE_MARGIN            bytes withheld from the advertised receive window
//   clr_state_t            receive-buffer clear FSM encoding
//   rx_beat_t              one output beat (data + valid byte count)
//   wr_end_offset()        exclusive end offset of a byte-enabled write
//   keep_mask()            mask keeping the first n bytes of an MSB-first word
package sitcpxg_rx_pkg;

  localparam int ADDR_W_MIN  = 12;
  localparam int ADDR_W_MAX  = 16;
  localparam int LANES       = 8;
  localparam int BYTE_W      = 8;
  localparam int SIZE_MARGIN = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_CLR_WAIT = 2'd1,
    ST_CLR_REQ  = 2'd2
  } clr_state_t;

  typedef struct packed {
    logic [LANES*BYTE_W-1:0] d;
    logic [3:0]              b;
  } rx_beat_t;

  // Enable bit 7 is byte offset 0, so the highest-offset byte written sits
  // at the lowest set bit; the write ends just past it (8 - bit index).
  function automatic logic [3:0] wr_end_offset(input logic [LANES-1:0] wenb);
    logic [3:0] r;
    r = 4'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (wenb[i]) r = 4'(LANES - i);
    end
    return r;
  endfunction

  // nbytes in 1..8; nbytes==8 shifts the all-ones pattern out entirely.
  function automatic logic [LANES*BYTE_W-1:0] keep_mask(input logic [3:0] nbytes);
    return ~({(LANES*BYTE_W){1'b1}} >> (BYTE_W * nbytes));
  endfunction

endpackage

// File: rtl/sitcpxg_rx_buffer_if.sv
// rtl/sitcpxg_rx_buffer_if.sv - core/user-facing signal bundle of the SiTCPXG RX buffer
// Signals:
//   USER_RX_SIZE, USER_RX_CLR_ENB, USER_RX_CLR_REQ, USER_RX_RADR,
//   USER_RX_WADR, USER_RX_WENB, USER_RX_WDAT   SiTCPXG core RX buffer port
//   FLUSH, FLUSH_BUSY                           user flush request/status
//   RD_D, RD_B, RD_VALID, RD_READY              MSB-first output byte stream
//   FILL                                        committed, unread byte count
// Modports: slave = the buffer, master = core plus user logic driving it.
interface sitcpxg_rx_buffer_if #(
  parameter int ADDR_W = 16
);
  import sitcpxg_rx_pkg::*;

  logic [15:0]     USER_RX_SIZE;
  logic            USER_RX_CLR_ENB;
  logic            USER_RX_CLR_REQ;
  logic [15:0]     USER_RX_RADR;
  logic [15:0]     USER_RX_WADR;
  logic [7:0]      USER_RX_WENB;
  logic [63:0]     USER_RX_WDAT;
  logic            FLUSH;
  logic            FLUSH_BUSY;
  logic [63:0]     RD_D;
  logic [3:0]      RD_B;
  logic            RD_VALID;
  logic            RD_READY;
  logic [ADDR_W:0] FILL;

  modport slave (
    input  USER_RX_CLR_ENB, USER_RX_WADR, USER_RX_WENB, USER_RX_WDAT,
    input  FLUSH, RD_READY,
    output USER_RX_SIZE, USER_RX_CLR_REQ, USER_RX_RADR, FLUSH_BUSY,
    output RD_D, RD_B, RD_VALID, FILL
  );

  modport master (
    output USER_RX_CLR_ENB, USER_RX_WADR, USER_RX_WENB, USER_RX_WDAT,
    output FLUSH, RD_READY,
    input  USER_RX_SIZE, USER_RX_CLR_REQ, USER_RX_RADR, FLUSH_BUSY,
    input  RD_D, RD_B, RD_VALID, FILL
  );

endinterface

// File: rtl/sitcpxg_rx_ram.sv
// rtl/sitcpxg_rx_ram.sv - simple dual-port 64-bit RAM with byte write enables
// Ports:
//   clk    write and read clock
//   we     byte write enables; we[k] writes wdata[8k+7:8k]
//   waddr  write word address
//   wdata  write data
//   raddr  read word address, sampled every cycle
//   rdata  registered read data (1-cycle latency, returns pre-write contents)
module sitcpxg_rx_ram
  import sitcpxg_rx_pkg::*;
#(
  parameter int WORD_AW = 13
) (
  input  logic                    clk,
  input  logic [LANES-1:0]        we,
  input  logic [WORD_AW-1:0]      waddr,
  input  logic [LANES*BYTE_W-1:0] wdata,
  input  logic [WORD_AW-1:0]      raddr,
  output logic [LANES*BYTE_W-1:0] rdata
);

  logic [LANES*BYTE_W-1:0] mem [0:(1 << WORD_AW) - 1];

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we[k]) mem[waddr][k*BYTE_W +: BYTE_W] <= wdata[k*BYTE_W +: BYTE_W];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sitcpxg_rx_buffer.sv
// rtl/sitcpxg_rx_buffer.sv - SiTCPXG receive buffer: RAM, read pointer, output stream, clear handshake
// Ports:
//   XGMII_CLOCK  the only clock
//   RST          asynchronous active-high reset
//   bus          sitcpxg_rx_buffer_if.slave (core RX buffer port, FLUSH, RD_* stream, FILL)
// Parameter ADDR_W: byte-address width of the buffer RAM (12..16).
module sitcpxg_rx_buffer
  import sitcpxg_rx_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic               XGMII_CLOCK,
  input  logic               RST,
  sitcpxg_rx_buffer_if.slave bus
);

  localparam int WORD_AW = ADDR_W - 3;

  if (ADDR_W < ADDR_W_MIN || ADDR_W > ADDR_W_MAX) begin : g_bad_addr_w
    $error("sitcpxg_rx_buffer: ADDR_W out of range");
  end

  clr_state_t state;
  logic clr_req_q;
  logic flush_busy_q;

  // wptr: committed write end; rptr: accepted read position; fptr: next fetch
  // position, running ahead of rptr by the beats in flight or in the skid.
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W-1:0] fptr;

  logic       infl_vld;
  logic [2:0] infl_off;
  logic [3:0] infl_b;

  rx_beat_t   skid0;
  rx_beat_t   skid1;
  logic [1:0] skid_cnt;

  logic [63:0]       ram_rdata;
  logic              wr_en;
  logic [7:0]        ram_we;
  logic [ADDR_W-1:0] wr_next;
  logic [ADDR_W-1:0] avail;
  logic [ADDR_W-1:0] favail;
  logic [3:0]        room;
  logic [3:0]        fetch_b;
  logic [2:0]        occ;
  logic              pop;
  logic              issue;
  rx_beat_t          push_beat;
  logic              unused_wadr;

  // A write coinciding with the clear pulse is dropped from RAM and wptr alike.
  assign wr_en   = (bus.USER_RX_WENB != 8'd0) && (state != ST_CLR_REQ);
  assign ram_we  = wr_en ? bus.USER_RX_WENB : 8'd0;
  assign wr_next = {bus.USER_RX_WADR[ADDR_W-1:3], 3'b000}
                 + ADDR_W'(wr_end_offset(bus.USER_RX_WENB));
  assign unused_wadr = ^bus.USER_RX_WADR;

  assign avail   = wptr - rptr;
  assign favail  = wptr - fptr;
  assign room    = 4'd8 - {1'b0, fptr[2:0]};
  assign fetch_b = (favail < ADDR_W'(room)) ? favail[3:0] : room;

  // Fetches are credited against the 2-entry skid: in-flight plus stored
  // beats (after this cycle's pop) must leave a slot for the new one.
  assign pop   = (skid_cnt != 2'd0) && bus.RD_READY;
  assign occ   = {1'b0, skid_cnt} + {2'b00, infl_vld} - {2'b00, pop};
  assign issue = (state == ST_RUN) && (favail != '0) && (occ < 3'd2);

  // Align the fetched word so the beat's first byte lands in [63:56] and
  // zero every byte past the count sampled at fetch time.
  always_comb begin
    push_beat   = '0;
    push_beat.d = (ram_rdata << (BYTE_W * infl_off)) & keep_mask(infl_b);
    push_beat.b = infl_b;
  end

  sitcpxg_rx_ram #(
    .WORD_AW(WORD_AW)
  ) u_ram (
    .clk  (XGMII_CLOCK),
    .we   (ram_we),
    .waddr(bus.USER_RX_WADR[ADDR_W-1:3]),
    .wdata(bus.USER_RX_WDAT),
    .raddr(fptr[ADDR_W-1:3]),
    .rdata(ram_rdata)
  );

  always_ff @(posedge XGMII_CLOCK or posedge RST) begin
    if (RST) begin
      state        <= ST_RUN;
      clr_req_q    <= 1'b0;
      flush_busy_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.FLUSH) begin
            state        <= ST_CLR_WAIT;
            flush_busy_q <= 1'b1;
          end
        end
        ST_CLR_WAIT: begin
          if (bus.USER_RX_CLR_ENB) begin
            state     <= ST_CLR_REQ;
            clr_req_q <= 1'b1;
          end
        end
        ST_CLR_REQ: begin
          state        <= ST_RUN;
          clr_req_q    <= 1'b0;
          flush_busy_q <= 1'b0;
        end
        default: begin
          state        <= ST_RUN;
          clr_req_q    <= 1'b0;
          flush_busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge XGMII_CLOCK or posedge RST) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      fptr     <= '0;
      infl_vld <= 1'b0;
      infl_off <= 3'd0;
      infl_b   <= 4'd0;
      skid0    <= '0;
      skid1    <= '0;
      skid_cnt <= 2'd0;
    end else if (state == ST_CLR_REQ) begin
      wptr     <= '0;
      rptr     <= '0;
      fptr     <= '0;
      infl_vld <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (wr_en) wptr <= wr_next;
      if (pop) rptr <= rptr + ADDR_W'(skid0.b);

      infl_vld <= issue;
      if (issue) begin
        fptr     <= fptr + ADDR_W'(fetch_b);
        infl_off <= fptr[2:0];
        infl_b   <= fetch_b;
      end

      // skid0 is always the head beat presented on RD_D/RD_B.
      case ({infl_vld, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= push_beat;
          else                  skid1 <= push_beat;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= push_beat;
          end else begin
            skid0 <= skid1;
            skid1 <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.USER_RX_SIZE    = 16'((1 << ADDR_W) - SIZE_MARGIN);
  assign bus.USER_RX_CLR_REQ = clr_req_q;
  assign bus.USER_RX_RADR    = 16'(rptr);
  assign bus.FLUSH_BUSY      = flush_busy_q;
  assign bus.RD_D            = skid0.d;
  assign bus.RD_B            = skid0.b;
  assign bus.RD_VALID        = (skid_cnt != 2'd0);
  assign bus.FILL            = {1'b0, avail};

endmodule
